// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard/forwarding controller.
// The pipeline (master) presents the ID-stage instruction and flush request.
// The controller (slave) returns the stall/issue decision, the EX-aligned
// forward selects and the in-flight writer count.
interface pipe_hazard_ctrl_if #(
    parameter int ADDR_W     = 5,
    parameter int NUM_STAGES = 3,
    parameter int SEL_W      = $clog2(NUM_STAGES)
);
    localparam int CNT_W = $clog2(NUM_STAGES + 1);

    logic              id_valid_i;
    logic [ADDR_W-1:0] id_rs_i;
    logic [ADDR_W-1:0] id_rt_i;
    logic              id_use_rs_i;
    logic              id_use_rt_i;
    logic              id_wr_en_i;
    logic [ADDR_W-1:0] id_rd_i;
    logic              id_load_i;
    logic              flush_i;
    logic              stall_o;
    logic              issue_o;
    logic [SEL_W-1:0]  fwd_a_o;
    logic [SEL_W-1:0]  fwd_b_o;
    logic [CNT_W-1:0]  inflight_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
        output id_wr_en_i, id_rd_i, id_load_i, flush_i,
        input  stall_o, issue_o, fwd_a_o, fwd_b_o, inflight_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
        input  id_wr_en_i, id_rd_i, id_load_i, flush_i,
        output stall_o, issue_o, fwd_a_o, fwd_b_o, inflight_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Parametrised hazard and forwarding controller for the in-order pipeline.
// Keeps a shadow scoreboard of destination registers in flight after ID,
// stalls on load-use hazards and registers EX-aligned forward selects.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int NUM_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = $clog2(NUM_STAGES)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    pipe_hazard_ctrl_if.slave   hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]         stall_cnt_o,
    output logic [31:0]         flush_cnt_o
`endif
);
    localparam int CNT_W = $clog2(NUM_STAGES + 1);
    // Entry NUM_STAGES is never forwarded and drops out on the next shift,
    // so its only trace is its contribution to inflight_o; it is not held.
    localparam int HELD = NUM_STAGES - 1;

    logic [HELD:1]     sb_valid;
    logic [HELD:1]     sb_wr;
    logic [HELD:1]     sb_load;
    logic [ADDR_W-1:0] sb_rd [1:HELD];

    logic [SEL_W-1:0]  match_a;
    logic [SEL_W-1:0]  match_b;
    logic              haz_a;
    logic              haz_b;
    logic              stall;
    logic              issue;
    logic [CNT_W-1:0]  inflight_nxt;

    // Youngest matching producer per source; scanning oldest-first lets the
    // smallest k overwrite. Register 0 and unused sources never match.
    always_comb begin
        match_a = '0;
        match_b = '0;
        haz_a   = 1'b0;
        haz_b   = 1'b0;
        for (int k = HELD; k >= 1; k--) begin
            if (sb_valid[k] && sb_wr[k] && hz.id_use_rs_i &&
                (hz.id_rs_i != '0) && (sb_rd[k] == hz.id_rs_i)) begin
                match_a = SEL_W'(k);
                haz_a   = sb_load[k] && (k <= LOAD_LAT);
            end
            if (sb_valid[k] && sb_wr[k] && hz.id_use_rt_i &&
                (hz.id_rt_i != '0) && (sb_rd[k] == hz.id_rt_i)) begin
                match_b = SEL_W'(k);
                haz_b   = sb_load[k] && (k <= LOAD_LAT);
            end
        end
    end

    // Flush overrides stall; both decisions are held low while in reset.
    assign stall      = rst_n_i & hz.id_valid_i & (haz_a | haz_b) & ~hz.flush_i;
    assign issue      = rst_n_i & hz.id_valid_i & ~stall & ~hz.flush_i;
    assign hz.stall_o = stall;
    assign hz.issue_o = issue;

    // Writer count of the scoreboard as it will look after this edge's shift.
    always_comb begin
        inflight_nxt = CNT_W'(issue & hz.id_wr_en_i);
        for (int k = 1; k <= HELD; k++) begin
            inflight_nxt = inflight_nxt + CNT_W'(sb_valid[k] & sb_wr[k]);
        end
    end

    // Scoreboard shift, bubble insertion and registered forward selects.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sb_valid      <= '0;
            sb_wr         <= '0;
            sb_load       <= '0;
            for (int k = 1; k <= HELD; k++) begin
                sb_rd[k] <= '0;
            end
            hz.fwd_a_o    <= '0;
            hz.fwd_b_o    <= '0;
            hz.inflight_o <= '0;
        end else begin
            sb_valid[1] <= issue;
            sb_wr[1]    <= hz.id_wr_en_i;
            sb_load[1]  <= hz.id_load_i;
            sb_rd[1]    <= hz.id_rd_i;
            for (int k = 2; k <= HELD; k++) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_wr[k]    <= sb_wr[k-1];
                sb_load[k]  <= sb_load[k-1];
                sb_rd[k]    <= sb_rd[k-1];
            end
            hz.fwd_a_o    <= issue ? match_a : '0;
            hz.fwd_b_o    <= issue ? match_b : '0;
            hz.inflight_o <= inflight_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall && (stall_cnt_o != 32'hFFFF_FFFF)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (hz.flush_i && (flush_cnt_o != 32'hFFFF_FFFF)) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (ADDR_W=5, NUM_STAGES=3, LOAD_LAT=1).
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl_if #(.ADDR_W(5), .NUM_STAGES(3)) hz ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipe_hazard_ctrl #(
        .ADDR_W(5), .NUM_STAGES(3), .LOAD_LAT(1)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .hz      (hz.slave)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       wr;
        logic [4:0] rd;
        logic       load;
        logic       flush;
        logic       exp_stall;
        logic       exp_issue;
        logic [1:0] exp_fa;
        logic [1:0] exp_fb;
        logic [1:0] exp_inf;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input int valid, input int rs, input int rt,
                                input int urs, input int urt, input int wr,
                                input int rd, input int load, input int flush,
                                input int st, input int is, input int fa,
                                input int fb, input int inf);
        vec_t v;
        v.valid = 1'(valid);   v.rs = 5'(rs);       v.rt = 5'(rt);
        v.use_rs = 1'(urs);    v.use_rt = 1'(urt);  v.wr = 1'(wr);
        v.rd = 5'(rd);         v.load = 1'(load);   v.flush = 1'(flush);
        v.exp_stall = 1'(st);  v.exp_issue = 1'(is);
        v.exp_fa = 2'(fa);     v.exp_fb = 2'(fb);   v.exp_inf = 2'(inf);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        hz.id_valid_i  = v.valid;
        hz.id_rs_i     = v.rs;
        hz.id_rt_i     = v.rt;
        hz.id_use_rs_i = v.use_rs;
        hz.id_use_rt_i = v.use_rt;
        hz.id_wr_en_i  = v.wr;
        hz.id_rd_i     = v.rd;
        hz.id_load_i   = v.load;
        hz.flush_i     = v.flush;
    endtask

    // One ID cycle: drive after the falling edge, check the combinational
    // decision, then check the registered outputs just after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        check({tag, " stall"}, 32'(hz.stall_o), 32'(v.exp_stall));
        check({tag, " issue"}, 32'(hz.issue_o), 32'(v.exp_issue));
        @(posedge clk);
        #1;
        check({tag, " fwd_a"}, 32'(hz.fwd_a_o), 32'(v.exp_fa));
        check({tag, " fwd_b"}, 32'(hz.fwd_b_o), 32'(v.exp_fb));
        check({tag, " inflight"}, 32'(hz.inflight_o), 32'(v.exp_inf));
    endtask

    initial begin
        vec_t idle;
        vec_t w1;
        vec_t w2;
        vec_t rdr;

        //             vld rs rt urs urt wr rd ld fl  st is fa fb inf
        vecs[0]  = mk(1, 1, 2, 1, 1, 1, 3, 0, 0,  0, 1, 0, 0, 1); // add r3
        vecs[1]  = mk(1, 3, 5, 1, 1, 1, 4, 0, 0,  0, 1, 1, 0, 2); // add r4<-r3,r5
        vecs[2]  = mk(1, 0, 0, 1, 0, 1, 2, 1, 0,  0, 1, 0, 0, 3); // lw r2
        vecs[3]  = mk(1, 2, 4, 1, 1, 1, 7, 0, 0,  1, 0, 0, 0, 2); // load-use stall
        vecs[4]  = mk(1, 2, 4, 1, 1, 1, 7, 0, 0,  0, 1, 2, 0, 2); // then issue, fwd 2
        vecs[5]  = mk(1, 1, 1, 1, 1, 1, 0, 0, 0,  0, 1, 0, 0, 2); // writes r0
        vecs[6]  = mk(1, 0, 0, 1, 1, 1, 8, 0, 0,  0, 1, 0, 0, 3); // reads r0
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[10] = mk(1, 0, 0, 1, 0, 1, 2, 1, 0,  0, 1, 0, 0, 1); // lw r2
        vecs[11] = mk(1, 2, 0, 1, 0, 1, 9, 0, 1,  0, 0, 0, 0, 1); // consumer + flush
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        vecs[14] = mk(1, 1, 0, 1, 0, 1, 6, 0, 0,  0, 1, 0, 0, 1); // r6 writer
        vecs[15] = mk(1, 1, 0, 1, 0, 1, 6, 0, 0,  0, 1, 0, 0, 2); // r6 writer
        vecs[16] = mk(1, 6, 6, 1, 1, 1,10, 0, 0,  0, 1, 1, 1, 3); // youngest wins
        vecs[17] = mk(1, 6,10, 0, 1, 0, 0, 0, 0,  0, 1, 0, 1, 2); // rs unused
        vecs[18] = mk(1,10, 6, 1, 1, 0, 0, 0, 0,  0, 1, 2, 0, 1); // r6 only in WB
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset fwd_a", 32'(hz.fwd_a_o), 32'd0);
        check("reset fwd_b", 32'(hz.fwd_b_o), 32'd0);
        check("reset inflight", 32'(hz.inflight_o), 32'd0);
        hz.id_valid_i = 1'b1;
        #1;
        check("reset issue held low", 32'(hz.issue_o), 32'd0);
        @(negedge clk);
        drive(idle);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef HAZARD_PERF_EN
        check("stall_cnt", stall_cnt, 32'd1);
        check("flush_cnt", flush_cnt, 32'd1);
`endif

        // Reset with two r11 writers in flight (the younger one a load).
        w1  = mk(1, 1, 0, 1, 0, 1, 11, 0, 0, 0, 1, 0, 0, 1);
        w2  = mk(1, 11, 0, 1, 0, 1, 11, 1, 0, 0, 1, 1, 0, 2);
        rdr = mk(1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        apply(w1, "rst w1");
        apply(w2, "rst w2");
        @(negedge clk);
        drive(rdr);
        #1;
        check("pre-reset stall", 32'(hz.stall_o), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("in-reset stall", 32'(hz.stall_o), 32'd0);
        check("in-reset issue", 32'(hz.issue_o), 32'd0);
        check("async fwd_a", 32'(hz.fwd_a_o), 32'd0);
        check("async inflight", 32'(hz.inflight_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset stall", 32'(hz.stall_o), 32'd0);
        check("post-reset issue", 32'(hz.issue_o), 32'd1);
        @(posedge clk);
        #1;
        check("post-reset fwd_a", 32'(hz.fwd_a_o), 32'd0);
        check("post-reset inflight", 32'(hz.inflight_o), 32'd0);
`ifdef HAZARD_PERF_EN
        check("stall_cnt after reset", stall_cnt, 32'd0);
`endif

        @(negedge clk);
        drive(idle);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
